// File: rtl/pixel_scrambler.sv
// ---------------------------------------------------------------------------
// pixel_scrambler
//
// Stream scrambler for RGB565 (or wider) pixels. Each accepted pixel is XORed
// with the low DATA_WIDTH bits of a 32-bit keystream word:
//   - start-of-frame pixels use the stored seed rotated left by 4*key_sel,
//     which re-synchronises the keystream at every frame boundary;
//   - all other pixels use the running Galois LFSR.
// After every accept the LFSR advances by one step from the word just used,
// so an SOF pixel also reseeds the LFSR from the rotated seed.
//
// The block is idle (in_ready low) until a seed has been loaded. Output is a
// single registered stage with ready/valid handshaking on both sides.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   key_sel    rotation index for SOF pixels (upstream counter value)
//   seed_load  load-seed strobe; enters RUN
//   seed       seed value (zero is replaced by 1)
//   in_valid   input pixel valid
//   in_data    input pixel
//   in_sof     start-of-frame flag of the input pixel
//   in_ready   block can accept a pixel this cycle
//   out_valid  output pixel valid
//   out_data   scrambled pixel
//   out_sof    start-of-frame flag of the output pixel
//   out_ready  downstream can accept a pixel
// ---------------------------------------------------------------------------
module pixel_scrambler #(
    parameter int DATA_WIDTH = 16,
    parameter int KEY_WIDTH  = 32,
    parameter int SEL_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SEL_WIDTH-1:0]  key_sel,
    input  logic                  seed_load,
    input  logic [KEY_WIDTH-1:0]  seed,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sof,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sof,
    input  logic                  out_ready
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam int ROT_BITS = $clog2(KEY_WIDTH);
    localparam logic [KEY_WIDTH-1:0] LFSR_TAPS = KEY_WIDTH'(32'h80200003);
    localparam logic [KEY_WIDTH-1:0] SEED_ONE  = KEY_WIDTH'(1);

    logic [0:0]            state_reg;
    logic [0:0]            state_next;
    logic [KEY_WIDTH-1:0]  seed_reg;
    logic [KEY_WIDTH-1:0]  lfsr_reg;
    logic [KEY_WIDTH-1:0]  lfsr_next;
    logic                  out_valid_reg;
    logic [DATA_WIDTH-1:0] out_data_reg;
    logic                  out_sof_reg;

    logic [ROT_BITS-1:0]   rot_amt;
    logic [KEY_WIDTH-1:0]  rot_key;
    logic [KEY_WIDTH-1:0]  ks_word;
    logic [KEY_WIDTH-1:0]  lfsr_step;
    logic [KEY_WIDTH-1:0]  seed_eff;
    logic [DATA_WIDTH-1:0] scrambled;
    logic                  accept;

    // Rotation amount is 4*key_sel taken modulo the key width; the cast keeps
    // only the low bits, which is exactly the modulo for a power-of-two width.
    assign rot_amt = ROT_BITS'({key_sel, 2'b00});

    // A right shift by the full key width yields zero, so rot_amt == 0 falls
    // out naturally as the unrotated seed.
    assign rot_key = (seed_reg << rot_amt) | (seed_reg >> (KEY_WIDTH - int'(rot_amt)));

    assign ks_word   = in_sof ? rot_key : lfsr_reg;
    assign lfsr_step = ks_word[0] ? ((ks_word >> 1) ^ LFSR_TAPS) : (ks_word >> 1);

    // An all-zero seed would lock the LFSR at zero forever.
    assign seed_eff = (seed == '0) ? SEED_ONE : seed;

    assign in_ready = (state_reg == RUN) && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_xor
            assign scrambled[gi] = in_data[gi] ^ ks_word[gi];
        end
    endgenerate

    // Only two ways out of the current state: a seed load enters RUN,
    // reset returns to IDLE.
    always_comb begin
        state_next = state_reg;
        if (seed_load) begin
            state_next = RUN;
        end
    end

    // A seed load takes priority over the step: a pixel accepted in the same
    // cycle is scrambled with the old keystream, then the new seed takes over.
    always_comb begin
        lfsr_next = lfsr_reg;
        if (seed_load) begin
            lfsr_next = seed_eff;
        end else if (accept) begin
            lfsr_next = lfsr_step;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            seed_reg      <= '0;
            lfsr_reg      <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sof_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            lfsr_reg  <= lfsr_next;
            if (seed_load) begin
                seed_reg <= seed_eff;
            end
            // Data and SOF only move on accept, so they stay stable while
            // the downstream stalls.
            if (accept) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= scrambled;
                out_sof_reg   <= in_sof;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sof   = out_sof_reg;

endmodule

// File: tb/tb_pixel_scrambler.sv
// ---------------------------------------------------------------------------
// tb_pixel_scrambler
//
// Self-checking bench for pixel_scrambler. A behavioural model (seed, LFSR,
// run flag, output-valid flag) runs alongside the DUT; every accepted pixel's
// expected output is pushed to a scoreboard queue at the drive edge and popped
// when the DUT presents it one cycle later. Directed scenarios also check
// hand-computed constants.
// ---------------------------------------------------------------------------
module tb_pixel_scrambler;

    localparam int DW = 16;
    localparam int KW = 32;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [SW-1:0] key_sel = '0;
    logic          seed_load = 1'b0;
    logic [KW-1:0] seed = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_sof = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_sof;
    logic          out_ready = 1'b1;

    pixel_scrambler #(
        .DATA_WIDTH(DW),
        .KEY_WIDTH (KW),
        .SEL_WIDTH (SW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .key_sel  (key_sel),
        .seed_load(seed_load),
        .seed     (seed),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_sof   (in_sof),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_sof  (out_sof),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sof;
    } exp_t;

    exp_t sb[$];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] m_seed = '0;
    logic [31:0] m_lfsr = '0;
    logic        m_run  = 1'b0;
    logic        m_ov   = 1'b0;
    exp_t        m_cur  = '0;
    logic        acc_last = 1'b0;

    function automatic logic [31:0] ref_rotl(input logic [31:0] v, input int n);
        logic [31:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[30:0], r[31]};
        return r;
    endfunction

    function automatic logic [31:0] ref_step(input logic [31:0] s);
        if (s[0]) return (s >> 1) ^ 32'h80200003;
        return s >> 1;
    endfunction

    function automatic logic m_ready();
        return m_run && (!m_ov || out_ready);
    endfunction

    // Advance the model with the currently driven inputs, then clock the DUT.
    task automatic step_cycle();
        logic        acc;
        logic [31:0] ks;
        exp_t        e;
        acc = m_ready() && in_valid;
        if (acc) begin
            ks = in_sof ? ref_rotl(m_seed, 4 * int'(key_sel)) : m_lfsr;
            e.data = in_data ^ ks[DW-1:0];
            e.sof  = in_sof;
            sb.push_back(e);
            m_cur  = e;
            m_lfsr = ref_step(ks);
        end
        if (acc) m_ov = 1'b1;
        else if (out_ready) m_ov = 1'b0;
        if (seed_load) begin
            m_seed = (seed == 32'h0) ? 32'h1 : seed;
            m_lfsr = m_seed;
            m_run  = 1'b1;
        end
        acc_last = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_seed = '0;
        m_lfsr = '0;
        m_run  = 1'b0;
        m_ov   = 1'b0;
        m_cur  = '0;
        sb.delete();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_sof !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got v=%b d=%h s=%b rdy=%b, want all 0",
                     out_valid, out_data, out_sof, in_ready);
        end
        model_reset();
        step_cycle();
        step_cycle();
        reset = 1'b1;
        // No seed yet: pixels offered must be ignored.
        in_valid = 1'b1;
        in_sof   = 1'b1;
        in_data  = 16'hBEEF;
        for (int i = 0; i < 2; i++) begin
            step_cycle();
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_no_accept: got rdy=%b v=%b, want 0 0", in_ready, out_valid);
            end
        end
        in_valid = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_basic();
        exp_t e;
        logic [DW-1:0] want [2];
        want[0] = 16'h0001;
        want[1] = 16'h0003;
        seed_load = 1'b1;
        seed      = 32'h1;
        key_sel   = 3'd0;
        step_cycle();
        seed_load = 1'b0;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL run_ready: got %b, want 1", in_ready);
        end
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_sof   = (i == 0);
            in_data  = 16'h0000;
            step_cycle();
            if (acc_last) begin
                e = sb.pop_front();
                vectors++;
                $display("txn basic d=%h s=%b exp=%h/%b", out_data, out_sof, e.data, e.sof);
                if (out_valid !== 1'b1 || out_data !== e.data || out_sof !== e.sof ||
                    out_data !== want[i]) begin
                    miscompares++;
                    $display("FAIL basic_pixel%0d: got v=%b d=%h s=%b, want v=1 d=%h s=%b",
                             i, out_valid, out_data, out_sof, want[i], e.sof);
                end
            end
        end
        in_valid = 1'b0;
        step_cycle();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_drain: got v=%b, want 0", out_valid);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_rotate();
        exp_t e;
        logic [31:0] seeds [2];
        seeds[0] = 32'h1;
        seeds[1] = 32'h0;
        for (int s = 0; s < 2; s++) begin
            in_valid  = 1'b0;
            seed_load = 1'b1;
            seed      = seeds[s];
            step_cycle();
            seed_load = 1'b0;
            for (int i = 0; i < 2; i++) begin
                in_valid = 1'b1;
                in_sof   = (i == 0);
                key_sel  = 3'd1;
                in_data  = (i == 0) ? 16'hFFFF : 16'h0000;
                step_cycle();
                if (acc_last) begin
                    e = sb.pop_front();
                    vectors++;
                    $display("txn rotate d=%h s=%b exp=%h/%b", out_data, out_sof, e.data, e.sof);
                    if (out_valid !== 1'b1 || out_data !== e.data || out_sof !== e.sof ||
                        out_data !== ((i == 0) ? 16'hFFEF : 16'h0008)) begin
                        miscompares++;
                        $display("FAIL rotate_seed%0d_pix%0d: got d=%h s=%b, want d=%h s=%b",
                                 s, i, out_data, out_sof, e.data, e.sof);
                    end
                end
            end
        end
        in_valid = 1'b0;
        step_cycle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_backpressure();
        exp_t e;
        exp_t held;
        held = '0;
        out_ready = 1'b1;
        seed_load = 1'b1;
        seed      = 32'hACE1_0BAD;
        step_cycle();
        seed_load = 1'b0;
        in_valid  = 1'b1;
        in_sof    = 1'b1;
        key_sel   = 3'd3;
        in_data   = 16'h1234;
        step_cycle();
        if (acc_last) begin
            e = sb.pop_front();
            held = e;
            vectors++;
            $display("txn bp_first d=%h s=%b exp=%h/%b", out_data, out_sof, e.data, e.sof);
            if (out_valid !== 1'b1 || out_data !== e.data || out_sof !== e.sof) begin
                miscompares++;
                $display("FAIL bp_first: got d=%h s=%b, want d=%h s=%b", out_data, out_sof, e.data, e.sof);
            end
        end
        out_ready = 1'b0;
        in_sof    = 1'b0;
        in_data   = 16'h5555;
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held.data || out_sof !== held.sof) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got rdy=%b v=%b d=%h s=%b, want rdy=0 v=1 d=%h s=%b",
                         i, in_ready, out_valid, out_data, out_sof, held.data, held.sof);
            end
            step_cycle();
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release_ready: got %b, want 1", in_ready);
        end
        step_cycle();
        if (acc_last) begin
            e = sb.pop_front();
            vectors++;
            $display("txn bp_refill d=%h s=%b exp=%h/%b", out_data, out_sof, e.data, e.sof);
            if (out_valid !== 1'b1 || out_data !== e.data || out_sof !== e.sof) begin
                miscompares++;
                $display("FAIL bp_refill: got v=%b d=%h s=%b, want v=1 d=%h s=%b",
                         out_valid, out_data, out_sof, e.data, e.sof);
            end
        end else begin
            vectors++;
            miscompares++;
            $display("FAIL bp_refill_accept: got no accept, want accept on drain cycle");
        end
        in_valid = 1'b0;
        step_cycle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_seed_collision();
        exp_t e;
        out_ready = 1'b1;
        seed_load = 1'b1;
        seed      = 32'hDEADBEEF;
        step_cycle();
        seed_load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            in_sof    = (i == 0 || i == 2);
            key_sel   = (i == 0) ? 3'd2 : 3'd0;
            in_data   = (i == 1) ? 16'hA5A5 : 16'h0000;
            seed_load = (i == 1);
            seed      = 32'h12345678;
            step_cycle();
            if (acc_last) begin
                e = sb.pop_front();
                vectors++;
                $display("txn collide d=%h s=%b exp=%h/%b", out_data, out_sof, e.data, e.sof);
                if (out_valid !== 1'b1 || out_data !== e.data || out_sof !== e.sof ||
                    (i == 2 && out_data !== 16'h5678) || (i == 3 && out_data !== 16'h2B3C)) begin
                    miscompares++;
                    $display("FAIL collide_pix%0d: got d=%h s=%b, want d=%h s=%b",
                             i, out_data, out_sof, e.data, e.sof);
                end
            end
        end
        seed_load = 1'b0;
        in_valid  = 1'b0;
        step_cycle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 80; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sof    = ($urandom_range(0, 7) == 0);
            key_sel   = SW'($urandom_range(0, 7));
            in_data   = DW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            seed_load = ($urandom_range(0, 15) == 0);
            seed      = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            #1;
            vectors++;
            if (in_ready !== m_ready()) begin
                miscompares++;
                $display("FAIL b2b_ready%0d: got %b, want %b", i, in_ready, m_ready());
            end
            step_cycle();
            if (acc_last) begin
                e = sb.pop_front();
                vectors++;
                $display("txn b2b d=%h s=%b exp=%h/%b", out_data, out_sof, e.data, e.sof);
                if (out_valid !== 1'b1 || out_data !== e.data || out_sof !== e.sof) begin
                    miscompares++;
                    $display("FAIL b2b_pix%0d: got v=%b d=%h s=%b, want v=1 d=%h s=%b",
                             i, out_valid, out_data, out_sof, e.data, e.sof);
                end
            end else begin
                vectors++;
                if (out_valid !== m_ov || (m_ov && (out_data !== m_cur.data || out_sof !== m_cur.sof))) begin
                    miscompares++;
                    $display("FAIL b2b_hold%0d: got v=%b d=%h s=%b, want v=%b d=%h s=%b",
                             i, out_valid, out_data, out_sof, m_ov, m_cur.data, m_cur.sof);
                end
            end
        end
        seed_load = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step_cycle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_midframe();
        exp_t e;
        out_ready = 1'b1;
        seed_load = 1'b1;
        seed      = 32'h0F0F0F0F;
        step_cycle();
        seed_load = 1'b0;
        in_valid  = 1'b1;
        in_sof    = 1'b0;
        in_data   = 16'h4321;
        step_cycle();
        if (acc_last) void'(sb.pop_front());
        out_ready = 1'b0;
        in_valid  = 1'b0;
        step_cycle();
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pre_reset_valid: got %b, want 1", out_valid);
        end
        reset = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_sof !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_clear: got v=%b d=%h s=%b rdy=%b, want all 0",
                     out_valid, out_data, out_sof, in_ready);
        end
        step_cycle();
        reset     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sof    = 1'b1;
        key_sel   = 3'd0;
        in_data   = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            step_cycle();
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_post_idle%0d: got rdy=%b v=%b, want 0 0", i, in_ready, out_valid);
            end
        end
        seed_load = 1'b1;
        seed      = 32'h5;
        step_cycle();
        seed_load = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_load_no_accept: got v=%b, want 0", out_valid);
        end
        step_cycle();
        if (acc_last) begin
            e = sb.pop_front();
            vectors++;
            $display("txn mid_first d=%h s=%b exp=%h/%b", out_data, out_sof, e.data, e.sof);
            if (out_valid !== 1'b1 || out_data !== e.data || out_sof !== e.sof || out_data !== 16'h1231) begin
                miscompares++;
                $display("FAIL mid_first_pixel: got v=%b d=%h s=%b, want v=1 d=1231 s=1",
                         out_valid, out_data, out_sof);
            end
        end else begin
            vectors++;
            miscompares++;
            $display("FAIL mid_first_accept: got no accept, want accept after seed load");
        end
        in_valid = 1'b0;
        step_cycle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rotate();
        test_backpressure();
        test_seed_collision();
        test_back_to_back();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pixel_scrambler.md
PIXEL_SCRAMBLER -- requirements
Module: pixel_scrambler

Interface
REQ-001 The block SHALL provide parameter DATA_WIDTH, default 16, pixel width in bits (RGB565).
REQ-002 The block SHALL provide parameter KEY_WIDTH, default 32, seed and LFSR width; legal value 32 only.
REQ-003 The block SHALL provide parameter SEL_WIDTH, default 3, key-select width, matching the upstream counter's COUNT_WIDTH.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- key_sel  input  SEL_WIDTH  rotation index, driven by the upstream counter's count.
- seed_load  input  1  load-seed strobe.
- seed  input  KEY_WIDTH  seed value.
- in_valid  input  1  input pixel valid.
- in_data  input  DATA_WIDTH  input pixel.
- in_sof  input  1  start-of-frame flag for the input pixel.
- in_ready  output  1  block can accept a pixel.
- out_valid  output  1  output pixel valid.
- out_data  output  DATA_WIDTH  scrambled pixel.
- out_sof  output  1  start-of-frame flag for the output pixel.
- out_ready  input  1  downstream can accept a pixel.

Function
REQ-005 The block SHALL implement a two-state FSM with states IDLE and RUN.
- Reset enters IDLE.
- seed_load=1 in either state enters or stays in RUN.
- No other transition exists.
REQ-006 On seed_load, the block SHALL store seed_reg <= seed, except that seed==0 SHALL store 32'h00000001.
- lfsr <= the same value in the same cycle.
REQ-007 in_ready SHALL be 0 in IDLE; in RUN it SHALL equal (!out_valid || out_ready).
REQ-008 A pixel SHALL be accepted on any rising edge where in_valid && in_ready.
REQ-009 The keystream word for an accepted pixel SHALL be:
- with in_sof=1: ks = rotate_left(seed_reg, 4*key_sel), with key_sel sampled in the accept cycle;
- otherwise: ks = lfsr.
REQ-010 On accept, the block SHALL register out_data <= in_data XOR ks[DATA_WIDTH-1:0] and out_sof <= in_sof, and set out_valid <= 1.
- Latency is exactly 1 cycle.
REQ-011 On accept, the block SHALL set lfsr <= step(ks).
- step(s) = (s>>1) XOR 32'h80200003 if s[0]=1; otherwise s>>1.
- lfsr SHALL NOT change without an accept or a seed_load.
REQ-012 out_valid SHALL clear when out_valid && out_ready && no accept occurs in the same cycle.
- out_data and out_sof SHALL be held stable while out_valid && !out_ready.
REQ-013 If seed_load and an accept occur in the same cycle:
- the pixel SHALL be scrambled with the pre-load seed_reg/lfsr;
- seed_reg and lfsr SHALL take the new seed, and the load SHALL override step().
REQ-014 A seed_load in IDLE SHALL NOT accept a pixel in that cycle, because in_ready is 0.
- The first accept SHALL occur no earlier than the next cycle.
REQ-015 The lfsr SHALL never reach 0, since seed_reg is nonzero and rotation preserves nonzero values.

Reset
REQ-016 On reset low, the block SHALL immediately set: state=IDLE, seed_reg=0, lfsr=0, out_valid=0, out_data=0, out_sof=0, in_ready=0.
REQ-017 Reset asserted mid-frame SHALL discard any held output pixel.
- After release, no pixel SHALL be accepted until a new seed_load.

Verification
REQ-018 seed_load with seed=0x00000001, key_sel=0, then SOF pixel 0x0000 -> out_data=0x0001, out_sof=1, one cycle after accept.
- The next non-SOF pixel 0x0000 -> out_data=0x0003 (lfsr=0x80200003).
REQ-019 seed=0x00000001, key_sel=1, SOF pixel 0xFFFF -> out_data=0xFFEF (ks=0x00000010).
- seed=0x00000000 -> behaves exactly as seed=0x00000001.
REQ-020 out_ready=0 with out_valid=1 for 5 cycles -> in_ready=0 and out_data/out_sof unchanged throughout.
- out_ready=1 -> held pixel drains, and a new accept occurs in the same cycle.
REQ-021 seed_load of 0x12345678 in the same cycle as an accepted non-SOF pixel:
- the pixel uses the old lfsr;
- the next SOF pixel with key_sel=0 is XORed with 0x5678.
REQ-022 Reset pulled low mid-frame while out_valid=1:
- all outputs 0 immediately, and in_ready=0 after release;
- the first accept occurs only after a seed_load.
